// File: rtl/mac_accumulator.sv
// mac_accumulator: Q1.15 multiply-accumulate with saturating wide accumulator,
// streaming operand beats in and one clamped Q1.15 result per dot product out.
// Optional feature: define MAC_ROUND_NEAREST_EN to round half up before the
// final shift; otherwise the result is truncated toward -inf.
module mac_accumulator #(
    parameter int DATA_BITS = 16,
    parameter int ACC_BITS  = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_a,
    input  logic [DATA_BITS-1:0] in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 sat_flag,
    output logic                 busy
);

    localparam int PROD_BITS = 2 * DATA_BITS;
    localparam int FRAC      = DATA_BITS - 1;

    localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
    localparam logic signed [ACC_BITS-1:0] OUT_MAX_EXT =
        {{(ACC_BITS-DATA_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] OUT_MIN_EXT =
        {{(ACC_BITS-DATA_BITS+1){1'b1}}, {(DATA_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        OUT
    } state_t;

    state_t state, next_state;

    logic                        in_hs;
    logic                        out_hs;
    logic signed [PROD_BITS-1:0] a_ext, b_ext, prod;
    logic signed [PROD_BITS-1:0] prod_r;
    logic                        prod_valid;
    logic                        prod_last;
    logic signed [ACC_BITS-1:0]  prod_ext;
    logic signed [ACC_BITS-1:0]  acc;
    logic                        acc_sat;
    logic        [ACC_BITS:0]    sum;
    logic                        add_ovf;
    logic signed [ACC_BITS-1:0]  acc_added;
    logic signed [ACC_BITS-1:0]  rounded;
    logic signed [ACC_BITS-1:0]  shifted;
    logic                        clamp_hi;
    logic                        clamp_lo;
    logic        [DATA_BITS-1:0] result;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // Operands are widened first so the multiply is done at full product width.
    assign a_ext = {{DATA_BITS{in_a[DATA_BITS-1]}}, in_a};
    assign b_ext = {{DATA_BITS{in_b[DATA_BITS-1]}}, in_b};
    assign prod  = a_ext * b_ext;

    assign prod_ext = {{(ACC_BITS-PROD_BITS){prod_r[PROD_BITS-1]}}, prod_r};

    // One guard bit exposes signed overflow of the accumulate.
    assign sum       = {acc[ACC_BITS-1], acc} + {prod_ext[ACC_BITS-1], prod_ext};
    assign add_ovf   = sum[ACC_BITS] ^ sum[ACC_BITS-1];
    assign acc_added = add_ovf ? (sum[ACC_BITS] ? ACC_MIN : ACC_MAX)
                               : sum[ACC_BITS-1:0];

`ifdef MAC_ROUND_NEAREST_EN
    localparam logic [ACC_BITS:0] HALF_LSB = (ACC_BITS+1)'(1) << (FRAC-1);

    logic [ACC_BITS:0] round_sum;

    // Adding half an output LSB can only overflow upward, so clamp to max.
    assign round_sum = {acc[ACC_BITS-1], acc} + HALF_LSB;
    assign rounded   = (round_sum[ACC_BITS] ^ round_sum[ACC_BITS-1]) ? ACC_MAX
                                                                     : round_sum[ACC_BITS-1:0];
`else
    assign rounded = acc;
`endif

    assign shifted  = rounded >>> FRAC;
    assign clamp_hi = shifted > OUT_MAX_EXT;
    assign clamp_lo = shifted < OUT_MIN_EXT;
    assign result   = clamp_hi ? {1'b0, {(DATA_BITS-1){1'b1}}} :
                      clamp_lo ? {1'b1, {(DATA_BITS-1){1'b0}}} :
                                 shifted[DATA_BITS-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and handshake outputs; in_ready drops as soon as a last beat is pending.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) next_state = ACCUM;
            end
            ACCUM: begin
                in_ready = ~(prod_valid & prod_last);
                if (prod_valid && prod_last) next_state = ROUND;
            end
            ROUND: begin
                next_state = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Product pipeline stage: captures each accepted beat with its last flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_r     <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else begin
            prod_valid <= in_hs;
            if (in_hs) begin
                prod_r    <= prod;
                prod_last <= in_last;
            end
        end
    end

    // Accumulator: adds the registered product, cleared when the result is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (out_hs) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (prod_valid) begin
            acc     <= acc_added;
            acc_sat <= acc_sat | add_ovf;
        end
    end

    // Result register: loaded once in ROUND and held through OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            sat_flag <= 1'b0;
        end else if (state == ROUND) begin
            out_data <= result;
            sat_flag <= acc_sat | clamp_hi | clamp_lo;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator; expectations are hand-computed
// Q1.15 results, and the rounding case follows MAC_ROUND_NEAREST_EN.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        sat_flag;
    logic        busy;

    int test_count = 0;
    int fail_count = 0;

    mac_accumulator #(.DATA_BITS(16), .ACC_BITS(40)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sat_flag (sat_flag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge; the block must be ready for it.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic last);
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        checkOutput("beat_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the last-beat edge; waits (bounded) for out_valid and checks it.
    task automatic checkResult(input string tag, input logic [15:0] exp_data,
                               input logic exp_sat);
        int lat;
        lat = 1;
        checkOutput({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 32'd3);
        checkOutput({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_data});
        checkOutput({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, exp_sat});
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        doReset();

        // Reset state
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {16'd0, out_data}, 32'h0);
        checkOutput("rst_sat", {31'd0, sat_flag}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 0.5 * 0.25 = 0.125
        applyStimulus(16'h4000, 16'h2000, 1'b1);
        checkOutput("single_busy", {31'd0, busy}, 32'd1);
        checkResult("single", 16'h1000, 1'b0);
        tick();
        checkOutput("single_valid_falls", {31'd0, out_valid}, 32'd0);
        checkOutput("single_idle", {31'd0, busy}, 32'd0);

        // -1 * -1 = +1 clamps to max positive
        applyStimulus(16'h8000, 16'h8000, 1'b1);
        checkResult("neg1sq", 16'h7FFF, 1'b1);
        tick();

        // 0.5 * 2^-15 is half an LSB
        applyStimulus(16'h4000, 16'h0001, 1'b1);
`ifdef MAC_ROUND_NEAREST_EN
        checkResult("halflsb", 16'h0001, 1'b0);
`else
        checkResult("halflsb", 16'h0000, 1'b0);
`endif
        tick();

        // Four back-to-back near-one squares with output stalled
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(16'h7FFF, 16'h7FFF, i == 3);
        checkResult("stall", 16'h7FFF, 1'b1);
        in_a     = 16'h7FFF;
        in_b     = 16'h7FFF;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall_data", {16'd0, out_data}, 32'h7FFF);
            checkOutput("stall_sat", {31'd0, sat_flag}, 32'd1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("stall_released", {31'd0, out_valid}, 32'd0);
        checkOutput("stall_in_ready_back", {31'd0, in_ready}, 32'd1);
        applyStimulus(16'h4000, 16'h2000, 1'b1);
        checkResult("fresh", 16'h1000, 1'b0);
        tick();

        // 0.75*0.5 + (-0.75)*0.5 = 0 with a two-cycle gap
        applyStimulus(16'h6000, 16'h4000, 1'b0);
        tick();
        tick();
        checkOutput("gap_busy", {31'd0, busy}, 32'd1);
        checkOutput("gap_no_output", {31'd0, out_valid}, 32'd0);
        applyStimulus(16'hA000, 16'h4000, 1'b1);
        checkResult("gap", 16'h0000, 1'b0);
        tick();

        // Reset one cycle after the second of three beats, colliding with the third
        applyStimulus(16'h4000, 16'h4000, 1'b0);
        applyStimulus(16'h4000, 16'h4000, 1'b0);
        reset    = 1'b1;
        in_a     = 16'h4000;
        in_b     = 16'h4000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checkOutput("abort_no_output", seen, 32'd0);
        applyStimulus(16'h2000, 16'h4000, 1'b1);
        checkResult("after_abort", 16'h1000, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16, Q1.15 operand and result width.
REQ-002 SHALL have parameter ACC_BITS, default 40, signed Q(ACC_BITS-30).30 accumulator width.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port in_valid, input, 1, operand beat valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-007 SHALL have port in_a, input, DATA_BITS, Q1.15 activation operand.
REQ-008 SHALL have port in_b, input, DATA_BITS, Q1.15 weight operand.
REQ-009 SHALL have port in_last, input, 1, marks final beat of a dot product.
REQ-010 SHALL have port out_valid, output, 1, unbiased result available.
REQ-011 SHALL have port out_ready, input, 1, downstream bias/activation stage accepts result.
REQ-012 SHALL have port out_data, output, DATA_BITS, Q1.15 unbiased sum.
REQ-013 SHALL have port sat_flag, output, 1, result was clamped; valid while out_valid.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCUM, ROUND, OUT.
REQ-016 Beat handshake SHALL occur on in_valid & in_ready; in_ready = 1 in IDLE/ACCUM, 0 in ROUND/OUT.
REQ-017 On handshake: signed full-precision product in_a*in_b (2*DATA_BITS, Q2.30) registered with its last flag at that edge; IDLE->ACCUM.
REQ-018 Cycle after product registration: product sign-extended to ACC_BITS and added to accumulator with saturation at ACC_BITS signed limits; saturation sets internal sat bit.
REQ-019 When the accumulated product carried last: ACCUM->ROUND at the same edge; in_ready already low from the cycle after the last handshake.
REQ-020 ROUND: out_data = acc >>> 15 (rounding per Configuration), clamped to [0x8000, 0x7FFF]; clamp or accumulator saturation sets sat_flag; registered, ROUND->OUT.
REQ-021 Latency: out_valid SHALL assert exactly 3 cycles after the cycle of the last-beat handshake.
REQ-022 OUT: out_data, sat_flag held stable while out_valid & ~out_ready.
REQ-023 Output handshake (out_valid & out_ready): accumulator and sat bit cleared, out_valid falls next cycle, OUT->IDLE.
REQ-024 Single-beat dot product (first beat has in_last) SHALL be legal.
REQ-025 in_valid with in_ready low SHALL be ignored; no beat lost or duplicated under back-to-back valid.
REQ-026 Gaps (in_valid low) inside a dot product SHALL not disturb the accumulator.

Reset
REQ-027 Reset SHALL have priority over every other event including handshakes in the same cycle.
REQ-028 Reset SHALL drive state IDLE, accumulator 0, product register invalid, out_valid 0, out_data 0x0000, sat_flag 0, busy 0; in_ready 1 in the first cycle after reset.
REQ-029 Reset mid-accumulation or in OUT SHALL discard the partial/pending result with no output produced.

Configuration
REQ-030 Macro MAC_ROUND_NEAREST_EN defined: ROUND adds 2^14 to the accumulator before the >>>15 shift (round half up), adder saturating.
REQ-031 Macro MAC_ROUND_NEAREST_EN undefined: plain arithmetic shift (truncation toward -inf), no rounding adder present.

Verification
REQ-032 Single beat a=0x4000, b=0x2000, last -> out_data 0x1000, sat_flag 0, out_valid 3 cycles after handshake.
REQ-033 Single beat a=0x8000, b=0x8000 (-1*-1) -> out_data 0x7FFF, sat_flag 1.
REQ-034 Single beat a=0x4000, b=0x0001 -> out_data 0x0001 with MAC_ROUND_NEAREST_EN, 0x0000 without.
REQ-035 Four back-to-back beats 0x7FFF*0x7FFF, out_ready held 0 for 5 cycles -> in_ready low until handshake, out_data 0x7FFF stable, sat_flag 1, then next dot product starts from 0.
REQ-036 Two beats 0x6000*0x4000 then 0xA000*0x4000 with a 2-cycle in_valid gap -> out_data 0x0000, sat_flag 0.
REQ-037 Reset asserted one cycle after the second of three beats -> no out_valid; subsequent single beat 0x2000*0x4000 -> out_data 0x1000.
